true_dpbram_be: RTL and testbench

//  Parametrised true dual-port block RAM: successor to the single-mode dual-port buffer.

---
 rtl/true_dpbram_be.sv | 207 ++++++++++++++++++++
 tb/tb_true_dpbram_be.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/true_dpbram_be.sv
// True dual-port RAM with byte enables, 1/2-cycle read pipeline, read-during-write modes
// and a hardware clear sequencer. Define COLLISION_DET_EN to add the sticky collision flag.
module true_dpbram_be #(
   parameter int unsigned DWIDTH         = 16,
   parameter int unsigned AWIDTH         = 12,
   parameter int unsigned MEM_SIZE       = 3840,
   parameter int unsigned BYTE_WIDTH     = 8,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned WRITE_MODE     = 0,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           clr_req,
   output logic                           ready,
   input  logic [AWIDTH-1:0]              addr0,
   input  logic                           ce0,
   input  logic [DWIDTH/BYTE_WIDTH-1:0]   we0,
   input  logic [DWIDTH-1:0]              d0,
   output logic [DWIDTH-1:0]              q0,
   output logic                           q0_valid,
   input  logic [AWIDTH-1:0]              addr1,
   input  logic                           ce1,
   input  logic [DWIDTH/BYTE_WIDTH-1:0]   we1,
   input  logic [DWIDTH-1:0]              d1,
   output logic [DWIDTH-1:0]              q1,
   output logic                           q1_valid
`ifdef COLLISION_DET_EN
   ,
   input  logic                           coll_clr,
   output logic                           coll_flag
`endif
);

   localparam int unsigned NB = DWIDTH / BYTE_WIDTH;
   localparam int unsigned MW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

   typedef enum logic [1:0] {StReset, StClear, StRun} state_e;

   state_e                state_q, state_d;
   logic [MW-1:0]         clr_addr_q, clr_addr_d;
   logic [DWIDTH-1:0]     mem [MEM_SIZE];

   logic                  acc0, acc1, wr0, wr1, in0, in1;
   logic [MW-1:0]         idx0, idx1;
   logic [DWIDTH-1:0]     old0, old1, res0, res1;
   logic                  res_vld0, res_vld1;
   logic [DWIDTH-1:0]     rd0_q, rd1_q;
   logic                  rd0_vld_q, rd1_vld_q;

   function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_word,
                                                     input logic [DWIDTH-1:0] wdata,
                                                     input logic [NB-1:0]     be);
      logic [DWIDTH-1:0] w;
      w = old_word;
      for (int unsigned i = 0; i < NB; i++) begin
         if (be[i]) w[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return w;
   endfunction

   // ---------------- clear sequencer ----------------
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         StReset: begin
            state_d    = (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_addr_d = '0;
         end
         StClear: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == MW'(MEM_SIZE - 1)) begin
               state_d    = StRun;
               clr_addr_d = '0;
            end
         end
         StRun: begin
            if (clr_req) begin
               state_d    = StClear;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = StReset;
            clr_addr_d = '0;
         end
      endcase
   end

   // Release of reset_n is expected to be synchronous to clk (upstream synchroniser).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? StClear : StReset;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign ready = (state_q == StRun);

   // ---------------- port access decode ----------------
   always_comb begin
      acc0     = ready & ce0;
      acc1     = ready & ce1;
      wr0      = acc0 & (|we0);
      wr1      = acc1 & (|we1);
      in0      = ({1'b0, addr0} < (AWIDTH + 1)'(MEM_SIZE));
      in1      = ({1'b0, addr1} < (AWIDTH + 1)'(MEM_SIZE));
      idx0     = addr0[MW-1:0];
      idx1     = addr1[MW-1:0];
      old0     = in0 ? mem[idx0] : '0;
      old1     = in1 ? mem[idx1] : '0;
      // Writes only produce a strobe in READ_FIRST / WRITE_FIRST modes.
      res_vld0 = acc0 & (~wr0 | (WRITE_MODE != 0));
      res_vld1 = acc1 & (~wr1 | (WRITE_MODE != 0));
      res0     = old0;
      res1     = old1;
      if (wr0 && (WRITE_MODE == 2)) res0 = in0 ? merge_bytes(old0, d0, we0) : '0;
      if (wr1 && (WRITE_MODE == 2)) res1 = in1 ? merge_bytes(old1, d1, we1) : '0;
   end

   // Port 1 lanes are assigned last so they win on a same-address, same-lane write.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         mem[clr_addr_q] <= '0;
      end else begin
         if (wr0 && in0) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (we0[i]) mem[idx0][i*BYTE_WIDTH +: BYTE_WIDTH] <= d0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
         if (wr1 && in1) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (we1[i]) mem[idx1][i*BYTE_WIDTH +: BYTE_WIDTH] <= d1[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // ---------------- read pipeline ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd0_q     <= '0;
         rd1_q     <= '0;
         rd0_vld_q <= 1'b0;
         rd1_vld_q <= 1'b0;
      end else begin
         rd0_vld_q <= res_vld0;
         rd1_vld_q <= res_vld1;
         if (res_vld0) rd0_q <= res0;
         if (res_vld1) rd1_q <= res1;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DWIDTH-1:0] out0_q, out1_q;
      logic              out0_vld_q, out1_vld_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            out0_q     <= '0;
            out1_q     <= '0;
            out0_vld_q <= 1'b0;
            out1_vld_q <= 1'b0;
         end else begin
            out0_vld_q <= rd0_vld_q;
            out1_vld_q <= rd1_vld_q;
            if (rd0_vld_q) out0_q <= rd0_q;
            if (rd1_vld_q) out1_q <= rd1_q;
         end
      end

      assign q0       = out0_q;
      assign q1       = out1_q;
      assign q0_valid = out0_vld_q;
      assign q1_valid = out1_vld_q;
   end else begin : g_lat1
      assign q0       = rd0_q;
      assign q1       = rd1_q;
      assign q0_valid = rd0_vld_q;
      assign q1_valid = rd1_vld_q;
   end

`ifdef COLLISION_DET_EN
   // ---------------- same-address collision flag ----------------
   logic coll_q;
   logic coll_set;

   assign coll_set = ready & ce0 & ce1 & (addr0 == addr1) & ((|we0) | (|we1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         coll_q <= 1'b0;
      end else if (coll_set) begin
         coll_q <= 1'b1;
      end else if (coll_clr) begin
         coll_q <= 1'b0;
      end
   end

   assign coll_flag = coll_q;
`endif

endmodule

// File: tb/tb_true_dpbram_be.sv
// Bench for true_dpbram_be: three configurations driven in parallel and checked against
// a word-level reference memory with latency-delayed expected outputs.
module tb_true_dpbram_be;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int MS = 16;
   localparam int ND = 3;
   localparam int RL [ND] = '{1, 2, 2};
   localparam int WM [ND] = '{1, 2, 0};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clr_req = 1'b0;
   logic coll_clr = 1'b0;
   logic          ce   [2];
   logic [1:0]    we   [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] d    [2];

   logic [ND-1:0]         ready_w, v0_w, v1_w;
   logic [ND-1:0][DW-1:0] q0_w, q1_w;
`ifdef COLLISION_DET_EN
   logic [ND-1:0]         coll_w;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      true_dpbram_be #(
         .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .BYTE_WIDTH(8),
         .READ_LATENCY(RL[g]), .WRITE_MODE(WM[g]), .CLEAR_ON_RESET(1)
      ) u_dut (
         .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .ready(ready_w[g]),
         .addr0(addr[0]), .ce0(ce[0]), .we0(we[0]), .d0(d[0]), .q0(q0_w[g]), .q0_valid(v0_w[g]),
         .addr1(addr[1]), .ce1(ce[1]), .we1(we[1]), .d1(d[1]), .q1(q1_w[g]), .q1_valid(v1_w[g])
`ifdef COLLISION_DET_EN
         , .coll_clr(coll_clr), .coll_flag(coll_w[g])
`endif
      );
   end

   // ---------------- reference model ----------------
   logic [DW-1:0] ref_mem [MS];
   bit            ready_m;
   int            clr_k;
   bit            coll_m;
   logic [DW-1:0] exp_q [ND][2];
   bit            exp_v [ND][2];
   logic [DW-1:0] p_q   [ND][2];
   bit            p_v   [ND][2];

   function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] dd,
                                         input logic [1:0] w);
      logic [DW-1:0] r;
      r = o;
      if (w[0]) r[7:0]  = dd[7:0];
      if (w[1]) r[15:8] = dd[15:8];
      return r;
   endfunction

   task automatic model_reset();
      ready_m = 1'b0;
      clr_k   = 0;
      coll_m  = 1'b0;
      for (int n = 0; n < ND; n++) begin
         for (int p = 0; p < 2; p++) begin
            exp_q[n][p] = '0; exp_v[n][p] = 1'b0;
            p_q[n][p]   = '0; p_v[n][p]   = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      logic [DW-1:0] old [2];
      logic [DW-1:0] nq  [ND][2];
      bit            nv  [ND][2];
      for (int p = 0; p < 2; p++) old[p] = (addr[p] < MS) ? ref_mem[addr[p][3:0]] : '0;
      for (int n = 0; n < ND; n++) begin
         for (int p = 0; p < 2; p++) begin
            nv[n][p] = 1'b0;
            nq[n][p] = '0;
            if (ready_m && ce[p]) begin
               if (we[p] == 2'b00) begin
                  nv[n][p] = 1'b1; nq[n][p] = old[p];
               end else if (WM[n] == 1) begin
                  nv[n][p] = 1'b1; nq[n][p] = old[p];
               end else if (WM[n] == 2) begin
                  nv[n][p] = 1'b1;
                  nq[n][p] = (addr[p] < MS) ? mrg(old[p], d[p], we[p]) : '0;
               end
            end
         end
      end
      if (ready_m) begin
         if (ce[0] && ce[1] && addr[0] == addr[1] && (we[0] != 0 || we[1] != 0)) coll_m = 1'b1;
         else if (coll_clr) coll_m = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (ce[p] && addr[p] < MS) ref_mem[addr[p][3:0]] = mrg(ref_mem[addr[p][3:0]], d[p], we[p]);
         end
         if (clr_req) begin
            ready_m = 1'b0;
            clr_k   = 0;
         end
      end else begin
         if (coll_clr) coll_m = 1'b0;
         ref_mem[clr_k] = '0;
         clr_k++;
         if (clr_k == MS) ready_m = 1'b1;
      end
      for (int n = 0; n < ND; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (RL[n] == 1) begin
               exp_v[n][p] = nv[n][p];
               if (nv[n][p]) exp_q[n][p] = nq[n][p];
            end else begin
               exp_v[n][p] = p_v[n][p];
               if (p_v[n][p]) exp_q[n][p] = p_q[n][p];
               p_v[n][p] = nv[n][p];
               if (nv[n][p]) p_q[n][p] = nq[n][p];
            end
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic compare_all();
      for (int n = 0; n < ND; n++) begin
         chk($sformatf("ready[%0d]", n), 32'(ready_w[n]), 32'(ready_m));
         chk($sformatf("q0_valid[%0d]", n), 32'(v0_w[n]), 32'(exp_v[n][0]));
         chk($sformatf("q1_valid[%0d]", n), 32'(v1_w[n]), 32'(exp_v[n][1]));
         chk($sformatf("q0[%0d]", n), 32'(q0_w[n]), 32'(exp_q[n][0]));
         chk($sformatf("q1[%0d]", n), 32'(q1_w[n]), 32'(exp_q[n][1]));
`ifdef COLLISION_DET_EN
         chk($sformatf("coll_flag[%0d]", n), 32'(coll_w[n]), 32'(coll_m));
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic set_port(input int p, input logic c, input logic [1:0] w,
                           input logic [AW-1:0] a, input logic [DW-1:0] dd);
      ce[p] = c; we[p] = w; addr[p] = a; d[p] = dd;
   endtask

   task automatic idle();
      set_port(0, 1'b0, 2'b00, '0, '0);
      set_port(1, 1'b0, 2'b00, '0, '0);
   endtask

   task automatic wait_ready(input string tag);
      int cnt;
      cnt = 0;
      while (ready_w[0] !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
      chk(tag, 32'(cnt), 32'd16);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset_n = 1'b1;

      // power-up clear, then every location reads zero
      wait_ready("t1_clear_cycles");
      for (int i = 0; i < MS; i++) begin
         set_port(0, 1'b1, 2'b00, AW'(i), '0);
         set_port(1, 1'b1, 2'b00, AW'(MS - 1 - i), '0);
         step();
      end
      idle();
      step();

      // write then read across ports
      set_port(0, 1'b1, 2'b11, 5'd5, 16'hABCD);
      step();
      idle();
      set_port(1, 1'b1, 2'b00, 5'd5, '0);
      step();
      chk("t2_q1_rl1", 32'(q1_w[0]), 32'hABCD);
      chk("t2_v1_rl1", 32'(v1_w[0]), 32'd1);
      idle();
      step();
      chk("t2_q1_rl2", 32'(q1_w[1]), 32'hABCD);
      chk("t2_v1_rl2", 32'(v1_w[1]), 32'd1);
      chk("t2_v1_rl1_pulse", 32'(v1_w[0]), 32'd0);

      // byte-lane write, read-first / write-first / no-change outputs
      set_port(0, 1'b1, 2'b01, 5'd5, 16'h1234);
      step();
      chk("t3_read_first", 32'(q0_w[0]), 32'hABCD);
      idle();
      step();
      chk("t3_write_first", 32'(q0_w[1]), 32'hAB34);
      chk("t3_no_change_v", 32'(v0_w[2]), 32'd0);
      set_port(1, 1'b1, 2'b00, 5'd5, '0);
      step();
      chk("t3_word", 32'(q1_w[0]), 32'hAB34);

      // dual write collision, port 1 wins
      set_port(0, 1'b1, 2'b11, 5'd7, 16'h1111);
      set_port(1, 1'b1, 2'b11, 5'd7, 16'h2222);
      step();
      idle();
      set_port(0, 1'b1, 2'b00, 5'd7, '0);
      step();
      chk("t4_p1_wins", 32'(q0_w[0]), 32'h2222);
      set_port(0, 1'b1, 2'b01, 5'd7, 16'hAAAA);
      set_port(1, 1'b1, 2'b10, 5'd7, 16'hBBBB);
      step();
      idle();
      set_port(0, 1'b1, 2'b00, 5'd7, '0);
      step();
      chk("t4_lane_merge", 32'(q0_w[0]), 32'hBBAA);
      idle();
`ifdef COLLISION_DET_EN
      step();
      chk("t4_coll_sticky", 32'(coll_w[0]), 32'd1);
      coll_clr = 1'b1;
      step();
      coll_clr = 1'b0;
      chk("t4_coll_cleared", 32'(coll_w[0]), 32'd0);
`endif

      // read-during-write from the other port returns old data
      set_port(0, 1'b1, 2'b11, 5'd3, 16'h5555);
      set_port(1, 1'b1, 2'b00, 5'd3, '0);
      step();
      chk("t5_old_data", 32'(q1_w[0]), 32'h0000);
      chk("t5_old_valid", 32'(v1_w[0]), 32'd1);
      idle();
      set_port(1, 1'b1, 2'b00, 5'd3, '0);
      step();
      chk("t5_new_data", 32'(q1_w[0]), 32'h5555);

      // out-of-range accesses
      idle();
      set_port(0, 1'b1, 2'b00, 5'd20, '0);
      step();
      chk("oor_read_q", 32'(q0_w[0]), 32'h0);
      chk("oor_read_v", 32'(v0_w[0]), 32'd1);
      set_port(0, 1'b1, 2'b11, 5'd4, 16'h4444);
      step();
      idle();
      set_port(1, 1'b1, 2'b11, 5'd20, 16'hDEAD);
      step();
      idle();
      set_port(0, 1'b1, 2'b00, 5'd4, '0);
      step();
      chk("oor_write_dropped", 32'(q0_w[0]), 32'h4444);
      idle();
      step();

      // reset in the middle of a requested clear
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (9) step();
      reset_n = 1'b0;
      #2;
      model_reset();
      compare_all();
      chk("t6_q1_reset", 32'(q1_w[1]), 32'h0);
      @(posedge clk);
      #1;
      compare_all();
      reset_n = 1'b1;
      wait_ready("t6_clear_cycles");
      set_port(0, 1'b1, 2'b00, 5'd5, '0);
      set_port(1, 1'b1, 2'b00, 5'd12, '0);
      step();
      chk("t6_cleared_q0", 32'(q0_w[0]), 32'h0);
      chk("t6_cleared_v0", 32'(v0_w[0]), 32'd1);

      // random traffic with frequent same-address pairs
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            ce[p]   = ($urandom_range(0, 3) != 0);
            we[p]   = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            addr[p] = AW'($urandom_range(0, 17));
            d[p]    = DW'($urandom);
         end
         if ($urandom_range(0, 1) != 0) addr[1] = addr[0];
         clr_req  = ($urandom_range(0, 149) == 0);
         coll_clr = ($urandom_range(0, 7) == 0);
         step();
      end
      idle();
      clr_req  = 1'b0;
      coll_clr = 1'b0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
